// File: rtl/store_trace_checker.sv
// store_trace_checker
//   Lockstep checker between the single-cycle golden core and the pipelined core.
//   Each core's data-memory store stream goes into its own FIFO. The two FIFO heads
//   are compared in program order, so pipeline latency and stalls do not matter.
//   The checker reports matches, the first mismatch, FIFO overflow and timeout.
// Ports
//   CLK, RESET (async, active-high), CLEAR (sync, same effect as RESET)
//   g_we/g_addr/g_data   golden store strobe, address and data
//   p_we/p_addr/p_data   pipelined store strobe, address and data
//   match_cnt            saturating count of equal compared pairs
//   mismatch/overflow/timeout  sticky error flags
//   err_addr/err_exp_data/err_got_data  contents of the first differing pair
//   idle                 both FIFOs empty and not failed
module store_trace_checker #(
    parameter int unsigned ADDR_SIZE = 10,
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 CLEAR,
    input  logic                 g_we,
    input  logic [ADDR_SIZE-1:0] g_addr,
    input  logic [DATA_SIZE-1:0] g_data,
    input  logic                 p_we,
    input  logic [ADDR_SIZE-1:0] p_addr,
    input  logic [DATA_SIZE-1:0] p_data,
    output logic [15:0]          match_cnt,
    output logic                 mismatch,
    output logic                 overflow,
    output logic                 timeout,
    output logic [ADDR_SIZE-1:0] err_addr,
    output logic [DATA_SIZE-1:0] err_exp_data,
    output logic [DATA_SIZE-1:0] err_got_data,
    output logic                 idle
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam int unsigned EW = ADDR_SIZE + DATA_SIZE;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StWait, StCmp, StFail} state_e;

    state_e          state_q, state_d;
    logic [EW-1:0]   g_mem [DEPTH];
    logic [EW-1:0]   p_mem [DEPTH];
    logic [PW-1:0]   g_wptr_q, g_wptr_d, g_rptr_q, g_rptr_d;
    logic [PW-1:0]   p_wptr_q, p_wptr_d, p_rptr_q, p_rptr_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic            failed, g_empty, p_empty, g_full, p_full;
    logic            do_cmp, heads_eq, cmp_bad, one_only, to_hit;
    logic            g_push_ok, p_push_ok, g_drop, p_drop;
    logic [EW-1:0]   g_head, p_head;

    assign failed  = (state_q == StFail);
    assign g_empty = (g_wptr_q == g_rptr_q);
    assign p_empty = (p_wptr_q == p_rptr_q);
    assign g_full  = (g_wptr_q[PW-1] != g_rptr_q[PW-1]) &&
                     (g_wptr_q[IW-1:0] == g_rptr_q[IW-1:0]);
    assign p_full  = (p_wptr_q[PW-1] != p_rptr_q[PW-1]) &&
                     (p_wptr_q[IW-1:0] == p_rptr_q[IW-1:0]);

    assign g_head   = g_mem[g_rptr_q[IW-1:0]];
    assign p_head   = p_mem[p_rptr_q[IW-1:0]];
    assign do_cmp   = !failed && !g_empty && !p_empty;
    assign heads_eq = (g_head == p_head);
    assign cmp_bad  = do_cmp && !heads_eq;

    // A full FIFO still accepts a push when its head pops on the same edge.
    assign g_push_ok = g_we && !failed && (!g_full || do_cmp);
    assign p_push_ok = p_we && !failed && (!p_full || do_cmp);
    assign g_drop    = g_we && !failed && g_full && !do_cmp;
    assign p_drop    = p_we && !failed && p_full && !do_cmp;

    assign one_only = (g_empty != p_empty);
    assign to_hit   = !failed && one_only && (timer_q == TW'(TIMEOUT - 1));

    assign idle = g_empty && p_empty && !failed;

    always_comb begin
        g_wptr_d = g_wptr_q + PW'(g_push_ok);
        p_wptr_d = p_wptr_q + PW'(p_push_ok);
        g_rptr_d = g_rptr_q + PW'(do_cmp);
        p_rptr_d = p_rptr_q + PW'(do_cmp);

        state_d = state_q;
        if (failed || cmp_bad || g_drop || p_drop || to_hit) begin
            state_d = StFail;
        end else if ((g_wptr_d == g_rptr_d) && (p_wptr_d == p_rptr_d)) begin
            state_d = StIdle;
        end else if ((g_wptr_d != g_rptr_d) && (p_wptr_d != p_rptr_d)) begin
            state_d = StCmp;
        end else begin
            state_d = StWait;
        end

        timer_d = timer_q;
        if (!failed) begin
            if (!one_only) begin
                timer_d = '0;
            end else if (!to_hit) begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= StIdle;
            g_wptr_q     <= '0;
            g_rptr_q     <= '0;
            p_wptr_q     <= '0;
            p_rptr_q     <= '0;
            timer_q      <= '0;
            match_cnt    <= '0;
            mismatch     <= 1'b0;
            overflow     <= 1'b0;
            timeout      <= 1'b0;
            err_addr     <= '0;
            err_exp_data <= '0;
            err_got_data <= '0;
        end else if (CLEAR) begin
            state_q      <= StIdle;
            g_wptr_q     <= '0;
            g_rptr_q     <= '0;
            p_wptr_q     <= '0;
            p_rptr_q     <= '0;
            timer_q      <= '0;
            match_cnt    <= '0;
            mismatch     <= 1'b0;
            overflow     <= 1'b0;
            timeout      <= 1'b0;
            err_addr     <= '0;
            err_exp_data <= '0;
            err_got_data <= '0;
        end else begin
            state_q  <= state_d;
            g_wptr_q <= g_wptr_d;
            g_rptr_q <= g_rptr_d;
            p_wptr_q <= p_wptr_d;
            p_rptr_q <= p_rptr_d;
            timer_q  <= timer_d;
            if (do_cmp && heads_eq && (match_cnt != 16'hFFFF)) begin
                match_cnt <= match_cnt + 16'd1;
            end
            if (cmp_bad) begin
                mismatch     <= 1'b1;
                err_addr     <= g_head[EW-1:DATA_SIZE];
                err_exp_data <= g_head[DATA_SIZE-1:0];
                err_got_data <= p_head[DATA_SIZE-1:0];
            end
            if (g_drop || p_drop) begin
                overflow <= 1'b1;
            end
            if (to_hit) begin
                timeout <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge CLK) begin
        if (!CLEAR && g_push_ok) begin
            g_mem[g_wptr_q[IW-1:0]] <= {g_addr, g_data};
        end
        if (!CLEAR && p_push_ok) begin
            p_mem[p_wptr_q[IW-1:0]] <= {p_addr, p_data};
        end
    end

endmodule

// File: tb/tb_store_trace_checker.sv
// Bench for store_trace_checker: directed scenarios followed by random store streams,
// checked against a queue-based reference model.
module tb_store_trace_checker;
    localparam int unsigned AS = 10;
    localparam int unsigned DS = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TIMEOUT = 64;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          CLEAR = 1'b0;
    logic          g_we = 1'b0, p_we = 1'b0;
    logic [AS-1:0] g_addr = '0, p_addr = '0;
    logic [DS-1:0] g_data = '0, p_data = '0;
    logic [15:0]   match_cnt;
    logic          mismatch, overflow, timeout, idle;
    logic [AS-1:0] err_addr;
    logic [DS-1:0] err_exp_data, err_got_data;

    store_trace_checker #(
        .ADDR_SIZE(AS), .DATA_SIZE(DS), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RESET(RESET), .CLEAR(CLEAR),
        .g_we(g_we), .g_addr(g_addr), .g_data(g_data),
        .p_we(p_we), .p_addr(p_addr), .p_data(p_data),
        .match_cnt(match_cnt), .mismatch(mismatch), .overflow(overflow),
        .timeout(timeout), .err_addr(err_addr), .err_exp_data(err_exp_data),
        .err_got_data(err_got_data), .idle(idle)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference model: one queue per core plus the reported results.
    logic [AS+DS-1:0] gq[$];
    logic [AS+DS-1:0] pq[$];
    logic [15:0]      m_match;
    int               m_timer;
    bit               m_mm, m_ov, m_to;
    logic [AS-1:0]    m_ea;
    logic [DS-1:0]    m_exp, m_got;

    task automatic model_reset();
        gq.delete();
        pq.delete();
        m_match = '0;
        m_timer = 0;
        m_mm = 0; m_ov = 0; m_to = 0;
        m_ea = '0; m_exp = '0; m_got = '0;
    endtask

    task automatic model_edge(input bit clr);
        logic [AS+DS-1:0] gh, ph;
        bit cmp, one, tohit;
        if (clr) begin
            model_reset();
            return;
        end
        if (m_mm || m_ov || m_to) return;
        cmp   = (gq.size() > 0) && (pq.size() > 0);
        one   = (gq.size() > 0) != (pq.size() > 0);
        tohit = one && (m_timer == TIMEOUT - 1);
        if (cmp) begin
            gh = gq.pop_front();
            ph = pq.pop_front();
            if (gh == ph) begin
                if (m_match != 16'hFFFF) m_match++;
            end else begin
                m_mm  = 1;
                m_ea  = gh[AS+DS-1:DS];
                m_exp = gh[DS-1:0];
                m_got = ph[DS-1:0];
            end
        end
        if (g_we) begin
            if (gq.size() < DEPTH) gq.push_back({g_addr, g_data});
            else m_ov = 1;
        end
        if (p_we) begin
            if (pq.size() < DEPTH) pq.push_back({p_addr, p_data});
            else m_ov = 1;
        end
        if (tohit) m_to = 1;
        else if (one) m_timer++;
        else m_timer = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("match_cnt", 64'(match_cnt), 64'(m_match));
        chk("mismatch", 64'(mismatch), 64'(m_mm));
        chk("overflow", 64'(overflow), 64'(m_ov));
        chk("timeout", 64'(timeout), 64'(m_to));
        chk("err_addr", 64'(err_addr), 64'(m_ea));
        chk("err_exp_data", 64'(err_exp_data), 64'(m_exp));
        chk("err_got_data", 64'(err_got_data), 64'(m_got));
        chk("idle", 64'(idle), 64'(gq.size() == 0 && pq.size() == 0 && !(m_mm || m_ov || m_to)));
    endtask

    task automatic step(input bit gw, input logic [AS-1:0] ga, input logic [DS-1:0] gd,
                        input bit pw, input logic [AS-1:0] pa, input logic [DS-1:0] pd,
                        input bit clr);
        @(negedge CLK);
        g_we = gw; g_addr = ga; g_data = gd;
        p_we = pw; p_addr = pa; p_data = pd;
        CLEAR = clr;
        @(posedge CLK);
        model_edge(clr);
        #1 check_all();
    endtask

    task automatic nop();
        step(0, '0, '0, 0, '0, '0, 0);
    endtask

    task automatic clr();
        step(0, '0, '0, 0, '0, '0, 1);
    endtask

    initial begin
        logic [AS+DS-1:0] pend[$];
        logic [AS+DS-1:0] e;
        logic [AS-1:0]    ga;
        logic [DS-1:0]    gd;
        bit               gw, pw, c;

        // Reset state, before any clock edge.
        model_reset();
        #1 check_all();
        RESET = 1'b0;

        // Asynchronous reset with three golden entries queued.
        for (int i = 0; i < 3; i++) step(1, AS'(i), DS'(i + 7), 0, '0, '0, 0);
        chk("queued_not_idle", 64'(idle), 64'd0);
        #1 RESET = 1'b1;
        #1 model_reset();
        check_all();
        chk("reset_idle", 64'(idle), 64'd1);
        #1 RESET = 1'b0;

        // Single matching pair, pipelined store four edges later.
        nop(); nop();
        step(1, 10'h004, 32'd5, 0, '0, '0, 0);
        nop(); nop(); nop();
        step(0, '0, '0, 1, 10'h004, 32'd5, 0);
        chk("latency_before", 64'(match_cnt), 64'd0);
        nop();
        chk("pair_match", 64'(match_cnt), 64'd1);
        chk("pair_idle", 64'(idle), 64'd1);
        chk("pair_no_mm", 64'(mismatch), 64'd0);

        // Mismatch, then a later equal pair must not count.
        clr();
        step(1, 10'h010, 32'h8, 0, '0, '0, 0);
        step(0, '0, '0, 1, 10'h010, 32'hD, 0);
        nop();
        chk("mm_flag", 64'(mismatch), 64'd1);
        chk("mm_addr", 64'(err_addr), 64'h010);
        chk("mm_exp", 64'(err_exp_data), 64'h8);
        chk("mm_got", 64'(err_got_data), 64'hD);
        step(1, 10'h020, 32'h1, 1, 10'h020, 32'h1, 0);
        nop(); nop();
        chk("mm_frozen_match", 64'(match_cnt), 64'd0);

        // Overflow on the ninth golden push.
        clr();
        for (int i = 0; i < 8; i++) step(1, AS'(i), DS'(i), 0, '0, '0, 0);
        chk("full_no_ovf", 64'(overflow), 64'd0);
        step(1, 10'h3FF, 32'h9, 0, '0, '0, 0);
        chk("ovf_ninth", 64'(overflow), 64'd1);

        // Full G FIFO accepts a push on an edge where its head pops.
        clr();
        for (int i = 0; i < 8; i++) step(1, AS'(i), DS'(i), 0, '0, '0, 0);
        step(0, '0, '0, 1, 10'd0, 32'd0, 0);
        step(1, 10'd8, 32'd8, 1, 10'd1, 32'd1, 0);
        chk("full_pop_no_ovf", 64'(overflow), 64'd0);
        nop();
        chk("full_pop_match", 64'(match_cnt), 64'd2);

        // Timeout exactly 64 edges after a lone golden entry appears.
        clr();
        step(1, 10'h055, 32'h1234, 0, '0, '0, 0);
        for (int i = 0; i < 63; i++) nop();
        chk("to_not_yet", 64'(timeout), 64'd0);
        nop();
        chk("to_hit", 64'(timeout), 64'd1);
        chk("to_no_mm", 64'(mismatch), 64'd0);

        // Twenty pairs, pipelined stream 3 cycles behind, pointers wrap.
        clr();
        for (int cyc = 0; cyc < 26; cyc++) begin
            step(cyc < 20, AS'(cyc * 4), DS'(cyc * 3 + 1),
                 (cyc >= 3) && (cyc < 23), AS'((cyc - 3) * 4), DS'((cyc - 3) * 3 + 1), 0);
        end
        chk("wrap_match", 64'(match_cnt), 64'd20);
        chk("wrap_idle", 64'(idle), 64'd1);
        clr();
        chk("clear_match", 64'(match_cnt), 64'd0);

        // Random store streams; the pipelined side replays golden stores late.
        for (int i = 0; i < 800; i++) begin
            c  = ($urandom_range(59) == 0);
            gw = ($urandom_range(2) == 0);
            ga = AS'($urandom);
            gd = DS'($urandom_range(15));
            if (gw) pend.push_back({ga, gd});
            pw = (pend.size() > 0) && ($urandom_range(2) == 0);
            e  = '0;
            if (pw) begin
                e = pend.pop_front();
                if ($urandom_range(40) == 0) e[0] = ~e[0];
            end
            step(gw, ga, gd, pw, e[AS+DS-1:DS], e[DS-1:0], c);
            if (c) pend.delete();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
